// File: rtl/sisc_pkg.sv
// Shared definitions for the sisc processor: address width, default
// instruction width and reset vector, and the fetch sequencer state encoding.
package sisc_pkg;

    localparam int ADDR_W = 16;
    localparam int INSTR_W_DEFAULT = 32;
    localparam logic [ADDR_W-1:0] RESET_VEC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: holds the PC, exposes PC+1, and on load takes
// either the sequential successor or the branch target.
module pc_reg
    import sisc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              load,
    input  logic              sel_br,
    input  logic [ADDR_W-1:0] br_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Successor wraps modulo 2^ADDR_W.
    assign pc_inc = pc_q + ADDR_W'(1);
    assign pc     = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = sel_br ? br_addr : pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer: fetches the word at the
// current PC over req/ack, holds it in ir, and advances the PC on retire.
module pc_fetch
    import sisc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int                INSTR_W   = INSTR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic [ADDR_W-1:0]  br_addr,
    input  logic               br_taken,
    input  logic               pc_write,
    input  logic               stall,
    input  logic               halt,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_inc,
    output logic               imem_req,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic               halted
);

    fetch_state_e       state_q;
    fetch_state_e       state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;
    logic               imem_req_q;
    logic               imem_req_d;
    logic               ir_valid_q;
    logic               ir_valid_d;
    logic               halted_q;
    logic               halted_d;
    logic               pc_load;

    pc_reg #(
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_f   (rst_f),
        .load    (pc_load),
        .sel_br  (br_taken),
        .br_addr (br_addr),
        .pc      (pc_out),
        .pc_inc  (pc_inc)
    );

    // A retire is accepted only in VALID with no stall; a halting retire
    // freezes the PC instead of loading it.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_load = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    state_d = VALID;
                    ir_d    = imem_data;
                end
            end
            VALID: begin
                if (pc_write && !stall) begin
                    state_d = halt ? HALT : FETCH;
                    pc_load = !halt;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered decodes of the next state so they change on
    // the same edge as the state itself.
    always_comb begin
        imem_req_d = (state_d == FETCH);
        ir_valid_d = (state_d == VALID);
        halted_d   = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            imem_req_q <= imem_req_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_req = imem_req_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a table of retire/fetch vectors with
// hand-computed expectations, plus asynchronous reset sequences.
module tb_pc_fetch;

    logic        clk;
    logic        rst_f;
    logic [15:0] br_addr;
    logic        br_taken;
    logic        pc_write;
    logic        stall;
    logic        halt;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [15:0] pc_out;
    logic [15:0] pc_inc;
    logic        imem_req;
    logic [31:0] ir;
    logic        ir_valid;
    logic        halted;

    pc_fetch #(
        .RESET_VEC (16'h0000),
        .INSTR_W   (32)
    ) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .br_addr   (br_addr),
        .br_taken  (br_taken),
        .pc_write  (pc_write),
        .stall     (stall),
        .halt      (halt),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .pc_out    (pc_out),
        .pc_inc    (pc_inc),
        .imem_req  (imem_req),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pcWrite;
        logic        stall;
        logic        halt;
        logic        brTaken;
        logic [15:0] brAddr;
        logic        imemAck;
        logic [31:0] imemData;
        logic [15:0] expPc;
        logic        expReq;
        logic        expValid;
        logic        expHalted;
        logic [31:0] expIr;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        req;
        logic        valid;
        logic        halted;
        logic [31:0] ir;
    } exp_t;

    exp_t expQ[$];
    vec_t vecs[22];
    int   checkCount = 0;
    int   passCount  = 0;

    function automatic vec_t mkVec(logic pw, logic st, logic hl, logic bt,
                                   logic [15:0] ba, logic ack, logic [31:0] dat,
                                   logic [15:0] ePc, logic eReq, logic eVal,
                                   logic eHlt, logic [31:0] eIr);
        vec_t v;
        v.pcWrite = pw;   v.stall = st;    v.halt = hl;      v.brTaken = bt;
        v.brAddr  = ba;   v.imemAck = ack; v.imemData = dat;
        v.expPc   = ePc;  v.expReq = eReq; v.expValid = eVal;
        v.expHalted = eHlt; v.expIr = eIr;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expectNow(input string name, input logic [15:0] ePc,
                             input logic eReq, input logic eVal,
                             input logic eHlt, input logic [31:0] eIr);
        exp_t e;
        e.name = name; e.pc = ePc; e.req = eReq;
        e.valid = eVal; e.halted = eHlt; e.ir = eIr;
        expQ.push_back(e);
    endtask

    // Pops the oldest expectation and compares every visible output.
    task automatic checkOutput();
        exp_t e;
        logic [15:0] incExp;
        if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = expQ.pop_front();
        incExp = e.pc + 16'd1;
        checkField({e.name, ".pc_out"},   32'(pc_out),   32'(e.pc));
        checkField({e.name, ".pc_inc"},   32'(pc_inc),   32'(incExp));
        checkField({e.name, ".imem_req"}, 32'(imem_req), 32'(e.req));
        checkField({e.name, ".ir_valid"}, 32'(ir_valid), 32'(e.valid));
        checkField({e.name, ".halted"},   32'(halted),   32'(e.halted));
        checkField({e.name, ".ir"},       ir,            e.ir);
    endtask

    // Drives one vector, records its expectation, and lets one edge pass.
    task automatic applyStimulus(input vec_t v, input string name);
        pc_write  = v.pcWrite;
        stall     = v.stall;
        halt      = v.halt;
        br_taken  = v.brTaken;
        br_addr   = v.brAddr;
        imem_ack  = v.imemAck;
        imem_data = v.imemData;
        expectNow(name, v.expPc, v.expReq, v.expValid, v.expHalted, v.expIr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        //              pw st hl bt brAddr    ack data           pc        req val hlt ir
        vecs[0]  = mkVec(0, 0, 0, 0, 16'h0000, 0, 32'h0,        16'h0000, 1, 0, 0, 32'h0);
        vecs[1]  = mkVec(0, 0, 0, 0, 16'h0000, 1, 32'h1111_0000, 16'h0000, 0, 1, 0, 32'h1111_0000);
        vecs[2]  = mkVec(1, 0, 0, 1, 16'h0005, 0, 32'h0,        16'h0005, 1, 0, 0, 32'h1111_0000);
        vecs[3]  = mkVec(0, 0, 0, 0, 16'h0000, 1, 32'hAAAA_0005, 16'h0005, 0, 1, 0, 32'hAAAA_0005);
        vecs[4]  = mkVec(1, 0, 0, 0, 16'h3333, 0, 32'h0,        16'h0006, 1, 0, 0, 32'hAAAA_0005);
        vecs[5]  = mkVec(0, 0, 0, 0, 16'h0000, 0, 32'h0,        16'h0006, 1, 0, 0, 32'hAAAA_0005);
        vecs[6]  = mkVec(1, 0, 0, 1, 16'h1234, 0, 32'h0,        16'h0006, 1, 0, 0, 32'hAAAA_0005);
        vecs[7]  = mkVec(0, 0, 0, 0, 16'h0000, 0, 32'h0,        16'h0006, 1, 0, 0, 32'hAAAA_0005);
        vecs[8]  = mkVec(0, 0, 0, 0, 16'h0000, 1, 32'h0000_0006, 16'h0006, 0, 1, 0, 32'h0000_0006);
        vecs[9]  = mkVec(1, 1, 0, 1, 16'h0040, 0, 32'h0,        16'h0006, 0, 1, 0, 32'h0000_0006);
        vecs[10] = mkVec(1, 0, 0, 1, 16'h0040, 0, 32'h0,        16'h0040, 1, 0, 0, 32'h0000_0006);
        vecs[11] = mkVec(0, 0, 0, 0, 16'h0000, 1, 32'h4040_4040, 16'h0040, 0, 1, 0, 32'h4040_4040);
        vecs[12] = mkVec(0, 0, 0, 0, 16'h0000, 1, 32'hDEAD_BEEF, 16'h0040, 0, 1, 0, 32'h4040_4040);
        vecs[13] = mkVec(1, 0, 0, 1, 16'hFFFF, 0, 32'h0,        16'hFFFF, 1, 0, 0, 32'h4040_4040);
        vecs[14] = mkVec(0, 0, 0, 0, 16'h0000, 1, 32'hFFFF_FFFF, 16'hFFFF, 0, 1, 0, 32'hFFFF_FFFF);
        vecs[15] = mkVec(1, 0, 0, 0, 16'h2222, 0, 32'h0,        16'h0000, 1, 0, 0, 32'hFFFF_FFFF);
        vecs[16] = mkVec(0, 0, 0, 0, 16'h0000, 1, 32'h0000_0000, 16'h0000, 0, 1, 0, 32'h0000_0000);
        vecs[17] = mkVec(1, 0, 0, 1, 16'h0010, 0, 32'h0,        16'h0010, 1, 0, 0, 32'h0000_0000);
        vecs[18] = mkVec(0, 0, 0, 0, 16'h0000, 1, 32'h0000_0010, 16'h0010, 0, 1, 0, 32'h0000_0010);
        vecs[19] = mkVec(1, 0, 1, 1, 16'h0099, 0, 32'h0,        16'h0010, 0, 0, 1, 32'h0000_0010);
        vecs[20] = mkVec(1, 0, 0, 1, 16'h0055, 1, 32'h5555_5555, 16'h0010, 0, 0, 1, 32'h0000_0010);
        vecs[21] = mkVec(0, 0, 0, 0, 16'h0000, 1, 32'h6666_6666, 16'h0010, 0, 0, 1, 32'h0000_0010);

        rst_f = 1'b0; pc_write = 1'b0; stall = 1'b0; halt = 1'b0;
        br_taken = 1'b0; br_addr = 16'h0; imem_ack = 1'b0; imem_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_f = 1'b1;
        expectNow("reset", 16'h0000, 0, 0, 0, 32'h0);
        checkOutput();

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            checkOutput();
        end

        // Asynchronous reset out of HALT, then refetch and branch.
        rst_f = 1'b0;
        #1;
        expectNow("rstHalt", 16'h0000, 0, 0, 0, 32'h0);
        checkOutput();
        @(posedge clk);
        #1;
        rst_f = 1'b1;
        v = mkVec(0, 0, 0, 0, 16'h0, 0, 32'h0, 16'h0000, 1, 0, 0, 32'h0);
        applyStimulus(v, "reIdle");
        checkOutput();
        v = mkVec(0, 0, 0, 0, 16'h0, 1, 32'h0000_0007, 16'h0000, 0, 1, 0, 32'h0000_0007);
        applyStimulus(v, "reFetch");
        checkOutput();
        v = mkVec(1, 0, 0, 1, 16'h0077, 0, 32'h0, 16'h0077, 1, 0, 0, 32'h0000_0007);
        applyStimulus(v, "branch77");
        checkOutput();

        // Reset mid-fetch with a late ack still asserted.
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0_BAD0;
        pc_write  = 1'b0;
        rst_f     = 1'b0;
        #1;
        expectNow("rstMidFetch", 16'h0000, 0, 0, 0, 32'h0);
        checkOutput();
        #1;
        rst_f = 1'b1;
        v = mkVec(0, 0, 0, 0, 16'h0, 1, 32'hBAD0_BAD0, 16'h0000, 1, 0, 0, 32'h0);
        applyStimulus(v, "lateAck");
        checkOutput();
        v = mkVec(0, 0, 0, 0, 16'h0, 1, 32'h1111_0000, 16'h0000, 0, 1, 0, 32'h1111_0000);
        applyStimulus(v, "zeroWait");
        checkOutput();

        if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard: got %0d leftover entries, expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program counter and instruction-fetch sequencer for the sisc processor. Holds the current PC and drives it as the instruction-memory address. Supplies PC+1 to the branch address calculator and loads either PC+1 or the calculator's branch address when the control unit retires an instruction. Fetches each instruction over a req/ack handshake into the instruction register and raises a valid flag for the control unit.

## Interface
- RESET_VEC, 16'h0000, PC value loaded on reset
- INSTR_W, 32, instruction width in bits

- clk  in  1  system clock, rising-edge
- rst_f  in  1  asynchronous, active-low reset
- br_addr  in  16  candidate branch target from branch address calculator
- br_taken  in  1  1 = load br_addr on retire, 0 = load pc_inc
- pc_write  in  1  single-cycle retire pulse from control unit
- stall  in  1  1 = ignore pc_write this cycle
- halt  in  1  sampled with pc_write; 1 = stop fetching
- imem_ack  in  1  instruction memory has imem_data valid
- imem_data  in  INSTR_W  instruction word
- pc_out  out  16  current PC, instruction-memory address
- pc_inc  out  16  pc_out + 1, combinational, to branch calculator
- imem_req  out  1  fetch request
- ir  out  INSTR_W  instruction register
- ir_valid  out  1  ir holds the instruction at pc_out
- halted  out  1  processor halted

## Operation
- FSM states: IDLE, FETCH, VALID, HALT.
- Reset (rst_f low, asynchronous) forces the following:
  - state = IDLE
  - pc_out = RESET_VEC
  - ir = 0
  - ir_valid = 0
  - imem_req = 0
  - halted = 0
- IDLE: held for exactly one cycle after reset release, then goes to FETCH.
- FETCH:
  - imem_req = 1 (Moore output of the state). pc_out is stable for the whole request.
  - On a clock edge with imem_ack = 1: ir <= imem_data, go to VALID.
  - imem_ack while not in FETCH is ignored.
- VALID:
  - ir_valid = 1.
  - On pc_write = 1 and stall = 0:
    - halt = 1: pc unchanged, go to HALT.
    - otherwise: pc <= br_taken ? br_addr : pc_inc, then go to FETCH.
  - pc_write with stall = 1 is dropped. The control unit re-pulses it later.
- HALT: halted = 1, imem_req = 0, ir_valid = 0. Only reset leaves this state.
- pc_write in IDLE, FETCH or HALT is ignored. It produces no PC change.
- Arithmetic: pc_inc = pc_out + 1, modulo 2^16 (16'hFFFF -> 16'h0000). The br_addr value is taken as is, with no range check.

## Timing
- First imem_req: asserted in the second cycle after rst_f deasserts (one cycle in IDLE).
- Fetch latency: ir and ir_valid update on the edge that samples imem_ack. The earliest is the first FETCH cycle, so a zero-wait memory gives one cycle per fetch.
- Retire to next request: the PC loads on the edge that samples pc_write. imem_req rises in the following cycle with the new pc_out. ir_valid falls on the same edge.
- pc_inc follows pc_out combinationally, in the same cycle.
- Reset mid-fetch: imem_req drops immediately (asynchronously). A late imem_ack after reset is ignored because the state is IDLE.
- pc_write and stall high in the same cycle: the stall wins, and nothing changes.
- br_taken, br_addr and halt matter only on the accepted pc_write edge.

## Structure
- The shared package sisc_pkg holds:
  - ADDR_W = 16
  - INSTR_W default
  - the fetch state enum (IDLE/FETCH/VALID/HALT, 2-bit encoding)
  - RESET_VEC default
- One sub-module, pc_reg: a 16-bit register with async active-low reset to RESET_VEC, a load enable, and a 2:1 next-value mux (pc_inc / br_addr).
- The FSM, ir and the output decode stay in pc_fetch.

## Test plan
- Reset then zero-wait memory (imem_ack tied 1) returning 32'h1111_0000 -> imem_req rises 2 cycles after release, with pc_out=0000. ir=32'h1111_0000 and ir_valid=1 one edge later.
- Sequential retire: pc_write pulse with br_taken=0 at pc=0005 -> pc_out=0006, ir_valid=0, then imem_req=1 next cycle. With a memory delaying ack 3 cycles, pc_out stays 0006 throughout.
- Branch: br_taken=1, br_addr=0x0040, pc_write -> pc_out=0040. Wrap: pc=FFFF, br_taken=0 -> pc_inc=0000, pc_out=0000.
- Stall: pc_write with stall=1 -> no PC change, stays in VALID. A later pc_write with stall=0 is accepted. A pc_write during FETCH is ignored.
- Halt: pc_write with halt=1 at pc=0010 -> halted=1, imem_req=0, pc_out=0010. Further pc_write and imem_ack are ignored until reset.
- Reset mid-fetch: assert rst_f low while imem_req=1 -> imem_req=0 and pc_out=RESET_VEC without waiting for a clock edge. Fetching restarts after release.
